// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-boundary (tear-free) updates.
// Optional blinking is compiled in with `define SEG7_BLINK_EN (adds blink_mask and BLINK_DIV).
module seg7_scan_driver #(
  parameter int NDIGITS  = 4,
  parameter int SCAN_DIV = 4
`ifdef SEG7_BLINK_EN
  ,
  parameter int BLINK_DIV = 8
`endif
) (
  input  logic                   clk_2,
  input  logic                   reset,
  input  logic                   load,
  input  logic [6*NDIGITS-1:0]   char_code,
  input  logic [NDIGITS-1:0]     dp_in,
`ifdef SEG7_BLINK_EN
  input  logic [NDIGITS-1:0]     blink_mask,
`endif
  output logic [7:0]             SEG,
  output logic [NDIGITS-1:0]     DIG,
  output logic                   frame_start
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {BLANK, ON, GAP} state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [CW-1:0]          cnt;
  logic [6*NDIGITS-1:0]   disp_code;
  logic [6*NDIGITS-1:0]   pend_code;
  logic [NDIGITS-1:0]     disp_dp;
  logic [NDIGITS-1:0]     pend_dp;
  logic                   pend_valid;
  logic                   wrap;
  logic                   dark;
  logic [5:0]             cur_code;
  logic                   cur_dp;

  function automatic logic [6:0] decode(input logic [5:0] code);
    case (code)
      6'd0:  decode = 7'h3F;  6'd1:  decode = 7'h06;  6'd2:  decode = 7'h5B;  6'd3:  decode = 7'h4F;
      6'd4:  decode = 7'h66;  6'd5:  decode = 7'h6D;  6'd6:  decode = 7'h7D;  6'd7:  decode = 7'h07;
      6'd8:  decode = 7'h7F;  6'd9:  decode = 7'h6F;  6'd10: decode = 7'h77;  6'd11: decode = 7'h7C;
      6'd12: decode = 7'h39;  6'd13: decode = 7'h5E;  6'd14: decode = 7'h79;  6'd15: decode = 7'h71;
      // Letters: A b C c d E F g H h I i J L n O o P q r S t U u y degree
      6'd16: decode = 7'h77;  6'd17: decode = 7'h7C;  6'd18: decode = 7'h39;  6'd19: decode = 7'h58;
      6'd20: decode = 7'h5E;  6'd21: decode = 7'h79;  6'd22: decode = 7'h71;  6'd23: decode = 7'h6F;
      6'd24: decode = 7'h76;  6'd25: decode = 7'h74;  6'd26: decode = 7'h06;  6'd27: decode = 7'h04;
      6'd28: decode = 7'h1E;  6'd29: decode = 7'h38;  6'd30: decode = 7'h54;  6'd31: decode = 7'h3F;
      6'd32: decode = 7'h5C;  6'd33: decode = 7'h73;  6'd34: decode = 7'h67;  6'd35: decode = 7'h50;
      6'd36: decode = 7'h6D;  6'd37: decode = 7'h78;  6'd38: decode = 7'h3E;  6'd39: decode = 7'h1C;
      6'd40: decode = 7'h6E;  6'd41: decode = 7'h63;
      default: decode = 7'h40;
    endcase
  endfunction

  assign wrap     = (state == GAP) && (idx == IW'(NDIGITS - 1));
  assign cur_code = disp_code[6*idx +: 6];
  assign cur_dp   = disp_dp[idx];

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;
  assign dark = blink_off & blink_mask[idx];
`else
  assign dark = 1'b0;
`endif

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state       <= BLANK;
      idx         <= '0;
      cnt         <= '0;
      SEG         <= '0;
      DIG         <= '0;
      frame_start <= 1'b0;
      disp_code   <= '0;
      pend_code   <= '0;
      disp_dp     <= '0;
      pend_dp     <= '0;
      pend_valid  <= 1'b0;
`ifdef SEG7_BLINK_EN
      blink_cnt   <= '0;
      blink_off   <= 1'b0;
`endif
    end else begin
      // Pins follow the state one cycle later; BLANK and GAP drive everything dark.
      SEG         <= '0;
      DIG         <= '0;
      frame_start <= 1'b0;
      if (state == ON) begin
        DIG         <= NDIGITS'(1) << idx;
        SEG         <= dark ? 8'h00 : {cur_dp, decode(cur_code)};
        frame_start <= (idx == '0) && (cnt == '0);
      end

      case (state)
        BLANK: begin
          state <= ON;
          idx   <= '0;
          cnt   <= '0;
        end
        ON: begin
          if (cnt == CW'(SCAN_DIV - 1)) begin
            state <= GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          state <= ON;
          idx   <= wrap ? '0 : idx + 1'b1;
        end
        default: state <= BLANK;
      endcase

      if (load) begin
        pend_code  <= char_code;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end

      // Frame boundary: a load arriving in this very cycle skips the pending stage.
      if (wrap) begin
        if (load) begin
          disp_code <= char_code;
          disp_dp   <= dp_in;
        end else if (pend_valid) begin
          disp_code <= pend_code;
          disp_dp   <= pend_dp;
        end
        pend_valid <= 1'b0;
`ifdef SEG7_BLINK_EN
        if (blink_cnt == BW'(BLINK_DIV - 1)) begin
          blink_cnt <= '0;
          blink_off <= ~blink_off;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a timeline-based reference model.
// Define SEG7_BLINK_EN on both files to exercise blinking with BLINK_DIV=2.
module tb_seg7_scan_driver;

  localparam int N      = 4;
  localparam int SD     = 2;
  localparam int SLOT   = SD + 1;
  localparam int FRAME  = N * SLOT;
  localparam int CODE_W = 6 * N;
`ifdef SEG7_BLINK_EN
  localparam int BD     = 2;
`endif

  logic              clk_2 = 1'b0;
  logic              reset = 1'b1;
  logic              load = 1'b0;
  logic [CODE_W-1:0] char_code = '0;
  logic [N-1:0]      dp_in = '0;
`ifdef SEG7_BLINK_EN
  logic [N-1:0]      blink_mask = '0;
`endif
  logic [7:0]        SEG;
  logic [N-1:0]      DIG;
  logic              frame_start;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(
    .NDIGITS(N),
    .SCAN_DIV(SD)
`ifdef SEG7_BLINK_EN
    , .BLINK_DIV(BD)
`endif
  ) dut (
    .clk_2(clk_2),
    .reset(reset),
    .load(load),
    .char_code(char_code),
    .dp_in(dp_in),
`ifdef SEG7_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .SEG(SEG),
    .DIG(DIG),
    .frame_start(frame_start)
  );

  // clock / reset block
  always #5 clk_2 = ~clk_2;

  // Glyph tables written from the character list: hex digits, then letters.
  logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [7:0] let_tab [26] = '{8'h77, 8'h7C, 8'h39, 8'h58, 8'h5E, 8'h79, 8'h71, 8'h6F,
                               8'h76, 8'h74, 8'h06, 8'h04, 8'h1E, 8'h38, 8'h54, 8'h3F,
                               8'h5C, 8'h73, 8'h67, 8'h50, 8'h6D, 8'h78, 8'h3E, 8'h1C,
                               8'h6E, 8'h63};

  // Reference model: k = output-timeline cycle since reset release (-1 while in reset).
  int   k = -1;
  int   m_disp [N];
  int   m_pend [N];
  bit   m_ddp  [N];
  bit   m_pdp  [N];
  bit   m_pvalid = 1'b0;

  function automatic logic [7:0] glyph(input int code);
    if (code < 16)      glyph = hex_tab[code];
    else if (code < 42) glyph = let_tab[code - 16];
    else                glyph = 8'h40;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h k=%0d t=%0t", tag, got, exp, k, $time);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      k = -1;
      m_pvalid = 1'b0;
      for (int d = 0; d < N; d++) begin
        m_disp[d] = 0; m_pend[d] = 0; m_ddp[d] = 1'b0; m_pdp[d] = 1'b0;
      end
    end else begin
      k = (k < 0) ? 0 : k + 1;
      if (load) begin
        for (int d = 0; d < N; d++) begin
          m_pend[d] = int'(char_code[6*d +: 6]);
          m_pdp[d]  = dp_in[d];
        end
        m_pvalid = 1'b1;
      end
      // The edge that starts the last gap of a frame is the commit point.
      if (k >= 1 && ((k - 1) % FRAME) == FRAME - 1) begin
        if (m_pvalid) begin
          for (int d = 0; d < N; d++) begin
            m_disp[d] = m_pend[d];
            m_ddp[d]  = m_pdp[d];
          end
        end
        m_pvalid = 1'b0;
      end
    end
  endtask

  task automatic compare_outputs();
    logic [7:0]   es;
    logic [N-1:0] ed;
    logic         ef;
    int           j, r, d, c;
    es = '0; ed = '0; ef = 1'b0;
    if (k >= 1) begin
      j = k - 1;
      r = j % FRAME;
      d = r / SLOT;
      c = r % SLOT;
      if (c < SD) begin
        ed = N'(1) << d;
        es = glyph(m_disp[d]) | (m_ddp[d] ? 8'h80 : 8'h00);
        ef = (d == 0) && (c == 0);
`ifdef SEG7_BLINK_EN
        if ((((j / FRAME) / BD) % 2) == 1 && blink_mask[d]) es = '0;
`endif
      end
    end
    check_eq("seg", SEG, es);
    check_eq("dig", DIG, ed);
    check_eq("frame_start", frame_start, ef);
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk_2);
    model_edge();
    @(negedge clk_2);
    compare_outputs();
  endtask

  task automatic wait_pos(input int pos);
    int n;
    n = 0;
    while (!(k >= 1 && ((k - 1) % FRAME) == pos) && n < 3 * FRAME) begin
      cycle();
      n++;
    end
    check_eq("wait_pos_timeout", (n < 3 * FRAME) ? 1 : 0, 1);
  endtask

  task automatic do_load(input logic [CODE_W-1:0] codes, input logic [N-1:0] dps);
    char_code = codes;
    dp_in     = dps;
    load      = 1'b1;
    cycle();
    load      = 1'b0;
  endtask

  initial begin
    @(negedge clk_2);
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    repeat (FRAME + 2) cycle();

    // Codes 3,2,1,0 on digits 3..0 with a dp on digit 0.
    do_load({6'd3, 6'd2, 6'd1, 6'd0}, 4'b0001);
    repeat (2 * FRAME) cycle();

    // Mid-frame load while digit 1 is lit.
    wait_pos(SLOT);
    do_load({6'd3, 6'd16, 6'd1, 6'd0}, 4'b0001);
    repeat (2 * FRAME) cycle();

    // Two loads in one frame: only the second may ever appear.
    wait_pos(0);
    do_load({6'd5, 6'd5, 6'd5, 6'd5}, 4'b0000);
    cycle();
    do_load({6'd42, 6'd42, 6'd42, 6'd42}, 4'b1111);
    repeat (2 * FRAME) cycle();

    // Load exactly on the edge that enters the wrap gap.
    wait_pos(FRAME - 2);
    do_load({6'd41, 6'd30, 6'd20, 6'd10}, 4'b1010);
    repeat (FRAME + 2) cycle();

    // Reset in the middle of digit 2.
    wait_pos(2 * SLOT);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (FRAME + 3) cycle();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      load  = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 249) == 0);
      if (load) begin
        char_code = CODE_W'($urandom());
        dp_in     = N'($urandom());
      end
`ifdef SEG7_BLINK_EN
      if ($urandom_range(0, 30) == 0) blink_mask = N'($urandom());
`endif
      cycle();
    end
    load  = 1'b0;
    reset = 1'b0;
    repeat (FRAME) cycle();

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
